// File: rtl/jk_writer_pkg.sv
// Shared state encoding and default parameters for the JK bank writer.
package jk_writer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_TOGGLE_PREF = 0;
  localparam int DEF_SETTLE_CYC  = 1;
  localparam int DEF_MAX_RETRY   = 2;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: J/K needed to move each flop from q to t in one edge.
module jk_excite
  import jk_writer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TOGGLE_PREF = DEF_TOGGLE_PREF
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  localparam logic TOG = (TOGGLE_PREF != 0);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Don't-care side of the table is filled with 1 when toggling is preferred.
    assign j[i] = (q[i] != t[i]) && (!q[i] || TOG);
    assign k[i] = (q[i] != t[i]) && ( q[i] || TOG);
  end

endmodule

// File: rtl/jk_bank_writer.sv
// Drives an external JK flip-flop bank to a target word: one-cycle J/K pulse,
// settle, verify against feedback, bounded retry, DONE or sticky ERR.
module jk_bank_writer
  import jk_writer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TOGGLE_PREF = DEF_TOGGLE_PREF,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic             C,
  input  logic             RESET,
  input  logic             TGT_VALID,
  input  logic [WIDTH-1:0] TGT,
  output logic             TGT_READY,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [WIDTH-1:0] ERR_MASK
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [SW-1:0]    settle_q, settle_d;

  logic             accept;
  logic [WIDTH-1:0] exc_t, exc_j, exc_k;

  assign TGT_READY = (state_q == IDLE) && !RESET;
  assign accept    = TGT_VALID && TGT_READY;

  // In IDLE the excitation targets the incoming word; on retry, the latched one.
  assign exc_t = (state_q == IDLE) ? TGT : tgt_q;

  jk_excite #(
    .WIDTH      (WIDTH),
    .TOGGLE_PREF(TOGGLE_PREF)
  ) u_excite (
    .q(Q_FB),
    .t(exc_t),
    .j(exc_j),
    .k(exc_k)
  );

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_mask_d = err_mask_q;
    retry_d    = retry_q;
    settle_d   = settle_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d      = TGT;
          j_d        = exc_j;
          k_d        = exc_k;
          err_d      = 1'b0;
          err_mask_d = '0;
          retry_d    = '0;
          state_d    = APPLY;
        end
      end
      APPLY: begin
        settle_d = SETTLE_INIT;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) state_d = CHECK;
        else                settle_d = settle_q - 1'b1;
      end
      CHECK: begin
        if (Q_FB == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_LIM) begin
          j_d     = exc_j;
          k_d     = exc_k;
          retry_d = retry_q + 1'b1;
          state_d = APPLY;
        end else begin
          err_d      = 1'b1;
          err_mask_d = Q_FB ^ tgt_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (RESET) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
      retry_q    <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
      retry_q    <= retry_d;
      settle_q   <= settle_d;
    end
  end

  assign J        = j_q;
  assign K        = k_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERR_MASK = err_mask_q;

endmodule

// File: tb/tb_jk_bank_writer.sv
// Two writers (set/reset and toggle encoding) share stimulus, each driving its own JK bank;
// a scoreboard of expected pulses and responses is checked by an independent monitor.
module tb_jk_bank_writer;

  localparam int W   = 4;
  localparam int S   = 1;
  localparam int MR  = 2;
  localparam int PER = 2 + S;

  logic C = 1'b0;
  always #5 C = ~C;

  logic         RESET = 1'b1, TGT_VALID = 1'b0;
  logic [W-1:0] TGT = '0;
  logic         rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
  logic [W-1:0] j0, k0, j1, k1, m0, m1;
  logic [W-1:0] bq0 = '0, bq1 = '0;
  logic [W-1:0] stuck = '0, pre_val = '0;
  logic         pre_en = 1'b1;
  logic [W-1:0] mq = '0;
  int           cyc = 0;

  typedef struct { logic [W-1:0] j0, k0, j1, k1; int at; } pulse_t;
  typedef struct { bit err; logic [W-1:0] mask, q; int at; } rsp_t;
  pulse_t pq[$];
  rsp_t   rq[$];
  int     n_chk = 0, n_pass = 0;

  function automatic logic [W-1:0] ff_next(input logic [W-1:0] q, j, k);
    logic [W-1:0] n;
    n = q;
    for (int i = 0; i < W; i++) begin
      if (j[i] && k[i]) n[i] = ~q[i];
      else if (j[i])    n[i] = 1'b1;
      else if (k[i])    n[i] = 1'b0;
    end
    return n;
  endfunction

  always @(posedge C) cyc <= cyc + 1;
  always @(posedge C) begin
    bq0 <= pre_en ? (pre_val & ~stuck) : (ff_next(bq0, j0, k0) & ~stuck);
    bq1 <= pre_en ? (pre_val & ~stuck) : (ff_next(bq1, j1, k1) & ~stuck);
  end

  jk_bank_writer #(.WIDTH(W), .TOGGLE_PREF(0), .SETTLE_CYC(S), .MAX_RETRY(MR)) dut0 (
    .C(C), .RESET(RESET), .TGT_VALID(TGT_VALID), .TGT(TGT), .TGT_READY(rdy0), .Q_FB(bq0),
    .J(j0), .K(k0), .BUSY(busy0), .DONE(done0), .ERR(err0), .ERR_MASK(m0));
  jk_bank_writer #(.WIDTH(W), .TOGGLE_PREF(1), .SETTLE_CYC(S), .MAX_RETRY(MR)) dut1 (
    .C(C), .RESET(RESET), .TGT_VALID(TGT_VALID), .TGT(TGT), .TGT_READY(rdy1), .Q_FB(bq1),
    .J(j1), .K(k1), .BUSY(busy1), .DONE(done1), .ERR(err1), .ERR_MASK(m1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Excitation table as written in the datasheet: only changing bits are driven.
  function automatic void exc(input logic [W-1:0] q, t, input bit tog,
                              output logic [W-1:0] j, k);
    j = '0; k = '0;
    for (int i = 0; i < W; i++)
      if (q[i] != t[i]) begin
        if (tog)       begin j[i] = 1'b1; k[i] = 1'b1; end
        else if (t[i]) j[i] = 1'b1;
        else           k[i] = 1'b1;
      end
  endfunction

  // Whole-transaction model: attempts until the bank matches or retries run out.
  task automatic model(input logic [W-1:0] t, input int a);
    logic [W-1:0] q, ja, ka, jb, kb, mask;
    int att;
    bit ok;
    q = mq; ok = 1'b0; att = 0;
    for (int r = 0; r <= MR && !ok; r++) begin
      exc(q, t, 1'b0, ja, ka);
      exc(q, t, 1'b1, jb, kb);
      if ((ja | ka) != '0) pq.push_back('{ja, ka, jb, kb, a + r * PER});
      q   = ff_next(q, ja, ka) & ~stuck;
      att = r + 1;
      ok  = (q == t);
    end
    mask = ok ? '0 : (q ^ t);
    rq.push_back('{!ok, mask, q, a + att * PER});
    mq = q;
  endtask

  task automatic send(input logic [W-1:0] t, output int acc);
    int n;
    n = 0; acc = -1;
    TGT = t; TGT_VALID = 1'b1;
    while (!rdy0 && n < 200) begin @(posedge C); #1; n++; end
    if (!rdy0) begin
      chk("ready_timeout", 32'd0, 32'd1);
      TGT_VALID = 1'b0;
      return;
    end
    @(posedge C); #1;
    acc = cyc;
    model(t, acc);
    chk("err_clr_on_accept", {err0, err1, m0, m1}, 32'd0);
    chk("busy_after_accept", {busy0, busy1}, 32'd3);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1 || pq.size() != 0 || rq.size() != 0) && n < 500) begin
      @(posedge C); #1; n++;
    end
    if (n >= 500) begin
      chk("idle_timeout", pq.size() + rq.size(), 32'd0);
      pq.delete(); rq.delete();
    end
  endtask

  task automatic preset(input logic [W-1:0] v);
    pre_val = v; pre_en = 1'b1;
    @(posedge C); #1;
    pre_en = 1'b0;
    mq = v & ~stuck;
  endtask

  initial begin : monitor
    logic   prev_act, act, e0p, e1p;
    pulse_t p;
    rsp_t   r;
    prev_act = 1'b0; e0p = 1'b0; e1p = 1'b0;
    forever begin
      @(negedge C);
      if (!RESET) begin
        act = ((j0 | k0 | j1 | k1) != '0);
        if (act) begin
          chk("pulse_one_cycle", prev_act, 32'd0);
          if (pq.size() == 0) chk("pulse_unexpected", {j0, k0, j1, k1}, 32'd0);
          else begin
            p = pq.pop_front();
            chk("pulse_j_sr", j0, p.j0);
            chk("pulse_k_sr", k0, p.k0);
            chk("pulse_j_tog", j1, p.j1);
            chk("pulse_k_tog", k1, p.k1);
            chk("pulse_cycle", cyc, p.at);
          end
        end
        prev_act = act;
        if (done0 || done1 || (err0 && !e0p) || (err1 && !e1p)) begin
          if (rq.size() == 0) chk("rsp_unexpected", {done0, done1, err0, err1}, 32'd0);
          else begin
            r = rq.pop_front();
            chk("done_sr", done0, !r.err);
            chk("done_tog", done1, !r.err);
            chk("err_sr", err0, r.err);
            chk("err_tog", err1, r.err);
            chk("mask_sr", m0, r.mask);
            chk("mask_tog", m1, r.mask);
            chk("bank_sr", bq0, r.q);
            chk("bank_tog", bq1, r.q);
            chk("rsp_cycle", cyc, r.at);
          end
        end
      end else prev_act = 1'b0;
      e0p = err0; e1p = err1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int a, b;
    logic [W-1:0] v;
    // Reset state
    repeat (2) @(posedge C);
    #1;
    chk("rst_jk", {j0, k0, j1, k1}, 32'd0);
    chk("rst_flags", {busy0, busy1, done0, done1, err0, err1}, 32'd0);
    chk("rst_mask", {m0, m1}, 32'd0);
    chk("rst_ready_low", {rdy0, rdy1}, 32'd0);
    pre_en = 1'b0; mq = '0;
    RESET = 1'b0;
    #1 chk("ready_after_rst", {rdy0, rdy1}, 32'd3);

    // Set/reset vs toggle encodings from 0000 and 1100
    preset(4'b0000); send(4'b1010, a); TGT_VALID = 1'b0; wait_idle();
    preset(4'b1100); send(4'b1010, a); TGT_VALID = 1'b0; wait_idle();

    // Stuck-at-0 bit exhausts retries; ERR stays until the next accept
    stuck = 4'b0001;
    preset(4'b0000); send(4'b0001, a); TGT_VALID = 1'b0; wait_idle();
    repeat (2) @(posedge C);
    #1;
    chk("err_sticky", {err0, err1}, 32'd3);
    chk("err_mask_sticky", {m0, m1}, {24'd0, 4'b0001, 4'b0001});
    stuck = '0;

    // Reset in SETTLE kills the transaction
    preset(4'b0000); send(4'b0011, a); TGT_VALID = 1'b0;
    @(negedge C); @(negedge C);
    chk("midop_busy", {busy0, busy1}, 32'd3);
    RESET = 1'b1;
    rq.delete(); pq.delete();
    repeat (2) @(posedge C);
    #1;
    chk("midop_rst_jk", {j0, k0, j1, k1}, 32'd0);
    chk("midop_rst_flags", {busy0, busy1, done0, done1, err0, err1}, 32'd0);
    chk("midop_rst_ready", {rdy0, rdy1}, 32'd0);
    @(negedge C); RESET = 1'b0;
    @(posedge C); #1;
    chk("midop_ready_after", {rdy0, rdy1, busy0, busy1, done0, done1}, 32'b110000);

    // No-change target then back-to-back accept in the DONE cycle
    preset(4'b0110);
    send(4'b0110, a);
    send(4'b1001, b);
    TGT_VALID = 1'b0;
    chk("b2b_accept_cycle", b, a + PER + 1);
    wait_idle();

    // Randomized traffic with occasional presets and stuck bits
    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(0, 3) == 0) begin
        TGT_VALID = 1'b0;
        wait_idle();
        stuck = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : '0;
        v = W'($urandom_range(0, 15));
        preset(v);
      end
      send(W'($urandom_range(0, 15)), a);
      if ($urandom_range(0, 1) == 0) begin
        TGT_VALID = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge C);
        #1;
      end
    end
    TGT_VALID = 1'b0;
    wait_idle();
    repeat (3) @(posedge C);
    #1;
    chk("queues_drained", pq.size() + rq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
